solid_box_scanner: RTL and testbench
====================================

Name: solid_box_scanner

Overview:
- Sequential collision query engine: takes a pixel-space hitbox and reports whether any map tile it overlaps is solid.
- Sits downstream of the shared solid map and upstream of the player/object movement logic.
- Replaces per-call combinational `is_solid` sweeps with one pipelined map read per cycle and early exit on the first solid tile.

Parameters:
- MAP_LOG2, 7, log2 of map dimension in tiles (128x128).
- TILE_SHIFT, 3, log2 of tile size in pixels (8 px).
- COORD_W, 16, width of signed pixel coordinates.
- SIZE_W, 8, width of unsigned box width/height.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  query present
- req_ready  out  1  block can accept a query (high only in IDLE)
- req_x  in  COORD_W  signed box left, pixels, integer part
- req_y  in  COORD_W  signed box top, pixels
- req_w  in  SIZE_W  box width, pixels
- req_h  in  SIZE_W  box height, pixels
- map_rd_en  out  1  map read strobe
- map_tx  out  MAP_LOG2  tile column address
- map_ty  out  MAP_LOG2  tile row address
- map_rd_data  in  1  solid bit; valid exactly one cycle after map_rd_en
- resp_valid  out  1  result available
- resp_ready  in  1  consumer takes result
- resp_hit  out  1  any overlapped tile solid
- resp_tx  out  MAP_LOG2  column of first solid tile (0 if no hit)
- resp_ty  out  MAP_LOG2  row of first solid tile (0 if no hit)

Behaviour:
- Reset (async, rst_n low): state IDLE, req_ready=1, map_rd_en=0, map_tx/ty=0, resp_valid=0, resp_hit=0, resp_tx/ty=0. Reset mid-scan aborts the query; no response is produced.
- States: IDLE, SETUP, SCAN, DRAIN, DONE.
- IDLE: accept when req_valid&&req_ready (cycle 0 edge); latch the inputs.
  - w==0 or h==0: go directly to DONE with hit=0; resp_valid is asserted in cycle 1.
- SETUP (cycle 1): compute tile bounds.
  - x0 = clamp0(x)>>TILE_SHIFT, x1 = clamp0(x+w-1)>>TILE_SHIFT; same for y.
  - clamp0 maps negatives to 0. Compute the sum in COORD_W+1 bits.
  - Tile indices use the low MAP_LOG2 bits (wrap), matching the package `is_solid` indexing.
  - Next state: SCAN at (x0,y0).
- SCAN: one read per cycle in raster order, x inner, y outer; map_rd_en=1.
  - Each cycle also checks map_rd_data for the previous read, using the registered address of that read.
  - Solid seen: capture that address, deassert map_rd_en, go DONE with hit=1. The read issued that cycle is discarded.
  - After issuing (x1,y1): go DRAIN.
- DRAIN: map_rd_en=0; check the last read's data; go DONE with hit=map_rd_data.
- Latency for N overlapped tiles, no hit: resp_valid rises in cycle N+3.
- Latency for first solid tile k (1-based raster index): resp_valid rises in cycle k+3.
- DONE: resp_valid=1; resp_hit/tx/ty stable until resp_ready. On resp_valid&&resp_ready, go IDLE; req_ready rises the next cycle (no same-cycle re-accept).
- Tile wrap: x1<x0 after masking (box straddles column 127→0) is legal. The column iterator counts from x0 to x1 modulo 2^MAP_LOG2, and rows the same way.
- Maximum N = ((255+7)>>3 + 1)^2 = 1089; iteration counters are MAP_LOG2+1 bits.

Decomposition:
- Add to the shared utils package:
  - typedef `tile_coord` (MAP_LOG2-bit x,y packed struct).
  - constants TILE_SHIFT and MAP_LOG2.
  - function `pix_to_tile(logic signed [15:0])` implementing the clamp0/shift/mask rule.
- The existing `box` typedef stays 16.16. The requester passes integer parts `box.x[31:16]` etc.
- One sub-module: `tile_range_iter`, raster x/y counter with start/last/advance/done, reusable for sprite-tile walks.

Test Plan:
- Empty map, box x=10,y=10,w=8,h=8 → reads tiles (1,1),(2,1),(1,2),(2,2) in order; resp_hit=0; resp_valid in cycle 7.
- Tile (2,1) solid, same box → map_rd_en stops after the 3rd read; resp_hit=1, resp_tx=2, resp_ty=1; resp_valid in cycle 5.
- x=-5,y=-3,w=4,h=4 → clamps to the single tile (0,0); solid there gives resp_hit=1 in cycle 4.
- w=0 → no map reads; resp_hit=0, resp_valid in cycle 1.
- resp_ready held low 5 cycles in DONE → outputs stable, req_ready=0; after the handshake, req_ready returns the next cycle.
- rst_n pulsed low during SCAN → all outputs return to reset values immediately; a new query then completes normally.

Source files
------------

// File: rtl/solid_box_scanner_pkg.sv
// Shared constants, types and pixel-to-tile helpers for the solid-map
// collision query engine and its tile walkers.
package solid_box_scanner_pkg;

  localparam int MAP_LOG2   = 7;
  localparam int TILE_SHIFT = 3;
  localparam int COORD_W    = 16;
  localparam int SIZE_W     = 8;

  typedef struct packed {
    logic [MAP_LOG2-1:0] x;
    logic [MAP_LOG2-1:0] y;
  } tile_coord;

  // 16.16 fixed-point hitbox; requesters pass the integer parts (x[31:16] etc.)
  typedef struct packed {
    logic signed [31:0] x;
    logic signed [31:0] y;
    logic        [31:0] w;
    logic        [31:0] h;
  } box;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SCAN,
    ST_DRAIN,
    ST_DONE
  } scan_state_e;

  // Wide form so that x+w-1 can be converted without overflow.
  function automatic logic [MAP_LOG2-1:0] pix_to_tile_wide(input logic signed [COORD_W:0] pix);
    logic [COORD_W:0] shifted;
    logic [MAP_LOG2-1:0] tile;
    shifted = '0;
    tile    = '0;
    if (!pix[COORD_W]) begin
      shifted = pix >> TILE_SHIFT;
      tile    = shifted[MAP_LOG2-1:0];
    end
    return tile;
  endfunction

  function automatic logic [MAP_LOG2-1:0] pix_to_tile(input logic signed [COORD_W-1:0] pix);
    return pix_to_tile_wide({pix[COORD_W-1], pix});
  endfunction

endpackage

// File: rtl/solid_box_scanner_tile_range_iter.sv
// Raster walker over a tile rectangle: x inner, y outer, both wrapping
// modulo the map size so boxes straddling the map edge are walked correctly.
module tile_range_iter
  import solid_box_scanner_pkg::*;
(
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      start_i,
  input  tile_coord first_i,
  input  tile_coord last_i,
  input  logic      advance_i,
  output tile_coord cur_o,
  output logic      done_o
);

  tile_coord cur_q, cur_d;
  tile_coord first_q, first_d;
  tile_coord last_q, last_d;

  always_comb begin
    cur_d   = cur_q;
    first_d = first_q;
    last_d  = last_q;
    if (start_i) begin
      cur_d   = first_i;
      first_d = first_i;
      last_d  = last_i;
    end else if (advance_i) begin
      if (cur_q.x == last_q.x) begin
        cur_d.x = first_q.x;
        cur_d.y = MAP_LOG2'(cur_q.y + 1'b1);
      end else begin
        cur_d.x = MAP_LOG2'(cur_q.x + 1'b1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cur_q   <= '0;
      first_q <= '0;
      last_q  <= '0;
    end else begin
      cur_q   <= cur_d;
      first_q <= first_d;
      last_q  <= last_d;
    end
  end

  assign cur_o  = cur_q;
  assign done_o = (cur_q == last_q);

endmodule

// File: rtl/solid_box_scanner.sv
// Sequential hitbox-vs-solid-map query: one map read per cycle in raster
// order, exiting early on the first solid tile.
module solid_box_scanner
  import solid_box_scanner_pkg::*;
(
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic signed [COORD_W-1:0]  req_x,
  input  logic signed [COORD_W-1:0]  req_y,
  input  logic        [SIZE_W-1:0]   req_w,
  input  logic        [SIZE_W-1:0]   req_h,
  output logic                       map_rd_en,
  output logic        [MAP_LOG2-1:0] map_tx,
  output logic        [MAP_LOG2-1:0] map_ty,
  input  logic                       map_rd_data,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic                       resp_hit,
  output logic        [MAP_LOG2-1:0] resp_tx,
  output logic        [MAP_LOG2-1:0] resp_ty
);

  scan_state_e state_q, state_d;

  logic signed [COORD_W-1:0] boxX_q, boxX_d, boxY_q, boxY_d;
  logic        [SIZE_W-1:0]  boxW_q, boxW_d, boxH_q, boxH_d;
  logic                      respHit_q, respHit_d;
  tile_coord                 respTile_q, respTile_d;
  logic                      pending_q;
  tile_coord                 prevTile_q;

  logic signed [COORD_W:0] endX, endY;
  tile_coord firstTile, lastTile, curTile;
  logic accept, hitSeen, zeroSize;
  logic iterStart, iterAdvance, iterDone;

  assign accept   = (state_q == ST_IDLE) && req_valid;
  assign zeroSize = (req_w == '0) || (req_h == '0);
  // map_rd_data only belongs to us when a read was issued the cycle before
  assign hitSeen  = pending_q && map_rd_data;

  always_comb begin
    endX = $signed({boxX_q[COORD_W-1], boxX_q})
         + $signed({{(COORD_W+1-SIZE_W){1'b0}}, boxW_q}) - 17'sd1;
    endY = $signed({boxY_q[COORD_W-1], boxY_q})
         + $signed({{(COORD_W+1-SIZE_W){1'b0}}, boxH_q}) - 17'sd1;
    firstTile.x = pix_to_tile(boxX_q);
    firstTile.y = pix_to_tile(boxY_q);
    lastTile.x  = pix_to_tile_wide(endX);
    lastTile.y  = pix_to_tile_wide(endY);
  end

  tile_range_iter u_iter (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .start_i   (iterStart),
    .first_i   (firstTile),
    .last_i    (lastTile),
    .advance_i (iterAdvance),
    .cur_o     (curTile),
    .done_o    (iterDone)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          state_d = zeroSize ? ST_DONE : ST_SETUP;
        end
      end
      ST_SETUP: state_d = ST_SCAN;
      ST_SCAN: begin
        if (hitSeen) begin
          state_d = ST_DONE;
        end else if (iterDone) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: state_d = ST_DONE;
      ST_DONE: begin
        if (resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The read issued in the cycle a hit is seen is simply ignored.
  always_comb begin
    req_ready   = (state_q == ST_IDLE);
    map_rd_en   = (state_q == ST_SCAN);
    resp_valid  = (state_q == ST_DONE);
    iterStart   = (state_q == ST_SETUP);
    iterAdvance = (state_q == ST_SCAN) && !hitSeen && !iterDone;
  end

  always_comb begin
    boxX_d     = boxX_q;
    boxY_d     = boxY_q;
    boxW_d     = boxW_q;
    boxH_d     = boxH_q;
    respHit_d  = respHit_q;
    respTile_d = respTile_q;
    if (accept) begin
      boxX_d     = req_x;
      boxY_d     = req_y;
      boxW_d     = req_w;
      boxH_d     = req_h;
      respHit_d  = 1'b0;
      respTile_d = '0;
    end else if (((state_q == ST_SCAN) || (state_q == ST_DRAIN)) && hitSeen) begin
      respHit_d  = 1'b1;
      respTile_d = prevTile_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      boxX_q     <= '0;
      boxY_q     <= '0;
      boxW_q     <= '0;
      boxH_q     <= '0;
      respHit_q  <= 1'b0;
      respTile_q <= '0;
      pending_q  <= 1'b0;
      prevTile_q <= '0;
    end else begin
      boxX_q     <= boxX_d;
      boxY_q     <= boxY_d;
      boxW_q     <= boxW_d;
      boxH_q     <= boxH_d;
      respHit_q  <= respHit_d;
      respTile_q <= respTile_d;
      pending_q  <= map_rd_en;
      prevTile_q <= curTile;
    end
  end

  assign map_tx   = curTile.x;
  assign map_ty   = curTile.y;
  assign resp_hit = respHit_q;
  assign resp_tx  = respTile_q.x;
  assign resp_ty  = respTile_q.y;

endmodule

// File: tb/tb_solid_box_scanner.sv
// Directed bench for solid_box_scanner: a behavioural solid map with
// one-cycle read latency, a read log, and hand-computed expectations.
module tb_solid_box_scanner;

  logic               clk;
  logic               rst_n;
  logic               req_valid;
  logic               req_ready;
  logic signed [15:0] req_x;
  logic signed [15:0] req_y;
  logic        [7:0]  req_w;
  logic        [7:0]  req_h;
  logic               map_rd_en;
  logic        [6:0]  map_tx;
  logic        [6:0]  map_ty;
  logic               map_rd_data;
  logic               resp_valid;
  logic               resp_ready;
  logic               resp_hit;
  logic        [6:0]  resp_tx;
  logic        [6:0]  resp_ty;

  int passCount  = 0;
  int totalCount = 0;

  logic [127:0] solid [128];
  logic [6:0]   readX [$];
  logic [6:0]   readY [$];

  solid_box_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_x       (req_x),
    .req_y       (req_y),
    .req_w       (req_w),
    .req_h       (req_h),
    .map_rd_en   (map_rd_en),
    .map_tx      (map_tx),
    .map_ty      (map_ty),
    .map_rd_data (map_rd_data),
    .resp_valid  (resp_valid),
    .resp_ready  (resp_ready),
    .resp_hit    (resp_hit),
    .resp_tx     (resp_tx),
    .resp_ty     (resp_ty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Map memory: data for the address strobed this cycle appears next cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      map_rd_data <= 1'b0;
    end else begin
      map_rd_data <= map_rd_en ? solid[map_ty][map_tx] : 1'b0;
    end
  end

  always @(posedge clk) begin
    if (rst_n && map_rd_en) begin
      readX.push_back(map_tx);
      readY.push_back(map_ty);
    end
  end

  task automatic clearMap();
    for (int i = 0; i < 128; i++) solid[i] = '0;
  endtask

  // Issues one query and returns the cycle (accept edge = 0) in which resp_valid was first seen.
  task automatic runQuery(input int x, input int y, input int w, input int h, output int cyc);
    readX.delete();
    readY.delete();
    @(negedge clk);
    req_x     = 16'(x);
    req_y     = 16'(y);
    req_w     = 8'(w);
    req_h     = 8'(h);
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    cyc = 1;
    while (!resp_valid && cyc < 3000) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic finishRsp();
    @(negedge clk);
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    totalCount++;
    if ({req_ready, map_rd_en, resp_valid, resp_hit} !== 4'b1000)
      $display("[TB] FAIL reset_ctrl: got %b, want 1000", {req_ready, map_rd_en, resp_valid, resp_hit});
    else passCount++;
    totalCount++;
    if ({map_tx, map_ty, resp_tx, resp_ty} !== 28'd0)
      $display("[TB] FAIL reset_addr: got %h, want 0", {map_tx, map_ty, resp_tx, resp_ty});
    else passCount++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_empty_map();
    int cyc;
    int expX [4] = '{1, 2, 1, 2};
    int expY [4] = '{1, 1, 2, 2};
    clearMap();
    runQuery(10, 10, 8, 8, cyc);
    totalCount++;
    if (cyc !== 7) $display("[TB] FAIL empty_latency: got %0d, want 7", cyc);
    else passCount++;
    totalCount++;
    if (readX.size() !== 4) $display("[TB] FAIL empty_reads: got %0d, want 4", readX.size());
    else passCount++;
    if (readX.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        totalCount++;
        if (readX[i] !== 7'(expX[i]) || readY[i] !== 7'(expY[i]))
          $display("[TB] FAIL empty_order%0d: got (%0d,%0d), want (%0d,%0d)", i, readX[i], readY[i], expX[i], expY[i]);
        else passCount++;
      end
    end
    totalCount++;
    if ({resp_hit, resp_tx, resp_ty} !== 15'd0)
      $display("[TB] FAIL empty_resp: got hit=%b (%0d,%0d), want 0 (0,0)", resp_hit, resp_tx, resp_ty);
    else passCount++;
    finishRsp();
  endtask

  task automatic test_first_hit();
    int cyc;
    clearMap();
    solid[1][2] = 1'b1;
    runQuery(10, 10, 8, 8, cyc);
    totalCount++;
    if (cyc !== 5) $display("[TB] FAIL hit_latency: got %0d, want 5", cyc);
    else passCount++;
    totalCount++;
    if (readX.size() !== 3) $display("[TB] FAIL hit_reads: got %0d, want 3", readX.size());
    else passCount++;
    totalCount++;
    if ({resp_hit, resp_tx, resp_ty} !== {1'b1, 7'd2, 7'd1})
      $display("[TB] FAIL hit_resp: got hit=%b (%0d,%0d), want 1 (2,1)", resp_hit, resp_tx, resp_ty);
    else passCount++;
    finishRsp();
  endtask

  task automatic test_clamp();
    int cyc;
    clearMap();
    solid[0][0] = 1'b1;
    runQuery(-5, -3, 4, 4, cyc);
    totalCount++;
    if (cyc !== 4) $display("[TB] FAIL clamp_latency: got %0d, want 4", cyc);
    else passCount++;
    totalCount++;
    if (readX.size() !== 1) $display("[TB] FAIL clamp_reads: got %0d, want 1", readX.size());
    else passCount++;
    totalCount++;
    if ({resp_hit, resp_tx, resp_ty} !== {1'b1, 7'd0, 7'd0})
      $display("[TB] FAIL clamp_resp: got hit=%b (%0d,%0d), want 1 (0,0)", resp_hit, resp_tx, resp_ty);
    else passCount++;
    finishRsp();
  endtask

  task automatic test_zero_size();
    int cyc;
    clearMap();
    solid[1][1] = 1'b1;
    runQuery(10, 10, 0, 8, cyc);
    totalCount++;
    if (cyc !== 1) $display("[TB] FAIL zero_latency: got %0d, want 1", cyc);
    else passCount++;
    totalCount++;
    if (readX.size() !== 0) $display("[TB] FAIL zero_reads: got %0d, want 0", readX.size());
    else passCount++;
    totalCount++;
    if (resp_hit !== 1'b0) $display("[TB] FAIL zero_hit: got %b, want 0", resp_hit);
    else passCount++;
    finishRsp();
  endtask

  task automatic test_wrap();
    int cyc;
    clearMap();
    solid[0][0] = 1'b1;
    // x=1016..1031 covers tile 127 then wraps to tile 0
    runQuery(1016, 0, 16, 1, cyc);
    totalCount++;
    if (cyc !== 5) $display("[TB] FAIL wrap_latency: got %0d, want 5", cyc);
    else passCount++;
    totalCount++;
    if (readX.size() < 2 || readX[0] !== 7'd127 || readX[1] !== 7'd0)
      $display("[TB] FAIL wrap_order: got %0d reads first x=%0d, want x=127 then 0", readX.size(), (readX.size() > 0) ? readX[0] : 7'd0);
    else passCount++;
    totalCount++;
    if ({resp_hit, resp_tx, resp_ty} !== {1'b1, 7'd0, 7'd0})
      $display("[TB] FAIL wrap_resp: got hit=%b (%0d,%0d), want 1 (0,0)", resp_hit, resp_tx, resp_ty);
    else passCount++;
    finishRsp();
  endtask

  task automatic test_backpressure();
    int cyc;
    clearMap();
    solid[1][2] = 1'b1;
    runQuery(10, 10, 8, 8, cyc);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      totalCount++;
      if ({resp_valid, req_ready, resp_hit, resp_tx, resp_ty} !== {1'b1, 1'b0, 1'b1, 7'd2, 7'd1})
        $display("[TB] FAIL hold%0d: got v=%b rdy=%b hit=%b (%0d,%0d), want v=1 rdy=0 hit=1 (2,1)", i, resp_valid, req_ready, resp_hit, resp_tx, resp_ty);
      else passCount++;
    end
    @(negedge clk);
    resp_ready = 1'b1;
    totalCount++;
    if (req_ready !== 1'b0) $display("[TB] FAIL handshake_rdy: got %b, want 0", req_ready);
    else passCount++;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    totalCount++;
    if ({req_ready, resp_valid} !== 2'b10)
      $display("[TB] FAIL after_handshake: got rdy=%b v=%b, want rdy=1 v=0", req_ready, resp_valid);
    else passCount++;
  endtask

  task automatic test_reset_mid_scan();
    int cyc;
    clearMap();
    readX.delete();
    @(negedge clk);
    req_x = 16'sd0; req_y = 16'sd0; req_w = 8'd255; req_h = 8'd255;
    req_valid = 1'b1;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    totalCount++;
    if (map_rd_en !== 1'b1) $display("[TB] FAIL scan_active: got %b, want 1", map_rd_en);
    else passCount++;
    rst_n = 1'b0;
    #1;
    totalCount++;
    if ({req_ready, map_rd_en, resp_valid, resp_hit, map_tx, map_ty, resp_tx, resp_ty} !== {4'b1000, 28'd0})
      $display("[TB] FAIL midscan_reset: got %b, want 1000 and zero addrs", {req_ready, map_rd_en, resp_valid, resp_hit});
    else passCount++;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    totalCount++;
    if ({resp_valid, map_rd_en, req_ready} !== 3'b001)
      $display("[TB] FAIL post_reset_idle: got v=%b en=%b rdy=%b, want 0 0 1", resp_valid, map_rd_en, req_ready);
    else passCount++;
    runQuery(10, 10, 8, 8, cyc);
    totalCount++;
    if (cyc !== 7 || resp_hit !== 1'b0)
      $display("[TB] FAIL post_reset_query: got cycle=%0d hit=%b, want 7 0", cyc, resp_hit);
    else passCount++;
    finishRsp();
  endtask

  initial begin
    req_valid  = 1'b0;
    resp_ready = 1'b0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0;
    clearMap();
    test_reset();
    test_empty_map();
    test_first_hit();
    test_clamp();
    test_zero_size();
    test_wrap();
    test_backpressure();
    test_reset_mid_scan();
    $display("%0d/%0d checks passed", passCount, totalCount);
    $finish;
  end

endmodule
